truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 121 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Programmable truth-table engine: N_OUT minterm masks swept row by row over a
// valid/ready stream, one row per cycle when the consumer is always ready.
module truth_table_sweeper #(
   parameter  int N_IN  = 4,
   parameter  int N_OUT = 10,
   parameter  int GROUP = 4,
   localparam int ROWS  = 1 << N_IN,
   localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [SEL_W-1:0] cfg_sel,
   input  logic [ROWS-1:0]  cfg_mask,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             row_valid,
   input  logic             row_ready,
   output logic [N_IN-1:0]  row_idx,
   output logic [N_OUT-1:0] row_out,
   output logic             row_grp_end
);

   localparam int GRP_W = $clog2(GROUP);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] row_idx_q, row_idx_d;
   logic [ROWS-1:0] mask_q [N_OUT];

   logic last_row;
   logic cfg_ok;
   logic grp_hit;

   assign last_row = (row_idx_q == {N_IN{1'b1}});

   // Masks stay frozen for the whole sweep; out-of-range selects are dropped.
   assign cfg_ok = cfg_we && (state_q != S_RUN) && (int'(cfg_sel) < N_OUT);

   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               row_idx_d = '0;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (row_ready) begin
               if (last_row) begin
                  state_d = S_DONE;
               end else begin
                  row_idx_d = row_idx_q + N_IN'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         row_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         row_idx_q <= row_idx_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int f = 0; f < N_OUT; f++) begin
            mask_q[f] <= '0;
         end
      end else if (cfg_ok) begin
         for (int f = 0; f < N_OUT; f++) begin
            if (int'(cfg_sel) == f) begin
               mask_q[f] <= cfg_mask;
            end
         end
      end
   end

   always_comb begin
      row_out = '0;
      for (int f = 0; f < N_OUT; f++) begin
         row_out[f] = mask_q[f][row_idx_q];
      end
   end

   // A group of one row ends on every row.
   if (GRP_W == 0) begin : g_grp_every
      assign grp_hit = 1'b1;
   end else begin : g_grp_mask
      assign grp_hit = &row_idx_q[GRP_W-1:0];
   end

   assign busy        = (state_q == S_RUN);
   assign row_valid   = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign row_idx     = row_idx_q;
   assign row_grp_end = row_valid && grp_hit;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised and directed bench for truth_table_sweeper against a row-level
// sweep model kept as plain integers and mask arrays.
module tb_truth_table_sweeper;
   localparam int N_IN  = 4;
   localparam int N_OUT = 10;
   localparam int GROUP = 4;
   localparam int ROWS  = 1 << N_IN;
   localparam int SEL_W = $clog2(N_OUT);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cfg_we;
   logic [SEL_W-1:0] cfg_sel;
   logic [ROWS-1:0]  cfg_mask;
   logic             start, abort, row_ready;
   logic             busy, done, row_valid, row_grp_end;
   logic [N_IN-1:0]  row_idx;
   logic [N_OUT-1:0] row_out;

   always #5 clk = ~clk;

   truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .GROUP(GROUP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_we      (cfg_we),
      .cfg_sel     (cfg_sel),
      .cfg_mask    (cfg_mask),
      .start       (start),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .row_valid   (row_valid),
      .row_ready   (row_ready),
      .row_idx     (row_idx),
      .row_out     (row_out),
      .row_grp_end (row_grp_end)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference: mask table plus "sweep in progress / current row / done pulse due".
   logic [ROWS-1:0] ref_mask [N_OUT];
   bit              ref_run;
   bit              ref_done;
   int              ref_row;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic ref_reset();
      for (int f = 0; f < N_OUT; f++) ref_mask[f] = '0;
      ref_run  = 1'b0;
      ref_done = 1'b0;
      ref_row  = 0;
   endtask

   task automatic ref_step(input bit s, input bit a, input bit r, input bit we,
                           input int sel, input logic [ROWS-1:0] m);
      bit was_run  = ref_run;
      bit was_done = ref_done;
      ref_done = 1'b0;
      if (we && !was_run && sel < N_OUT) ref_mask[sel] = m;
      if (was_run) begin
         if (a) begin
            ref_run = 1'b0;
         end else if (r) begin
            if (ref_row == ROWS - 1) begin
               ref_run  = 1'b0;
               ref_done = 1'b1;
            end else begin
               ref_row++;
            end
         end
      end else if (!was_done && s) begin
         ref_run = 1'b1;
         ref_row = 0;
      end
   endtask

   task automatic check_outputs();
      logic [N_OUT-1:0] exp_out;
      chk("busy", busy, ref_run);
      chk("row_valid", row_valid, ref_run);
      chk("done", done, ref_done);
      if (ref_run) begin
         for (int f = 0; f < N_OUT; f++) exp_out[f] = ref_mask[f][ref_row];
         chk("row_idx", row_idx, ref_row);
         chk("row_out", row_out, exp_out);
         chk("grp_end", row_grp_end, (ref_row % GROUP) == GROUP - 1);
      end else begin
         chk("grp_end_idle", row_grp_end, 0);
      end
   endtask

   task automatic cyc(input bit s, input bit a, input bit r, input bit we = 1'b0,
                      input int sel = 0, input logic [ROWS-1:0] m = '0);
      start     = s;
      abort     = a;
      row_ready = r;
      cfg_we    = we;
      cfg_sel   = SEL_W'(sel);
      cfg_mask  = m;
      @(posedge clk);
      ref_step(s, a, r, we, sel, m);
      #1;
      check_outputs();
   endtask

   task automatic finish_sweep();
      int guard = 0;
      while (ref_run && guard < 200) begin
         cyc(1'b0, 1'b0, 1'b1);
         guard++;
      end
      chk("sweep_bounded", guard < 200, 1);
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_mask = '0;
      start = 1'b0; abort = 1'b0; row_ready = 1'b0;
      ref_reset();
      #12;
      chk("rst_valid", row_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_idx", row_idx, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Two functions, full-speed sweep
      cyc(0, 0, 0, 1, 0, 16'h8888);
      cyc(0, 0, 0, 1, 5, 16'h111F);
      cyc(1, 0, 1);
      for (int r = 0; r < ROWS; r++) begin
         chk("f0_row", row_out[0], (r % 4) == 3);
         chk("f5_row", row_out[5], (r <= 4) || r == 8 || r == 12);
         chk("grp_row", row_grp_end, (r % 4) == 3);
         chk("seq_idx", row_idx, r);
         cyc(0, 0, 1);
      end
      chk("done_pulse", done, 1);
      cyc(0, 0, 1);
      chk("done_once", done, 0);

      // Backpressure on row 5, start during RUN ignored
      cyc(1, 0, 1);
      for (int r = 0; r < 5; r++) cyc(0, 0, 1);
      chk("bp_at5", row_idx, 5);
      cyc(1, 0, 0);
      chk("bp_hold1", row_idx, 5);
      cyc(0, 0, 0);
      chk("bp_hold2", row_idx, 5);
      cyc(0, 0, 1);
      chk("bp_next", row_idx, 6);
      finish_sweep();
      cyc(0, 0, 0);

      // Abort at row 9 with ready high
      cyc(1, 0, 1);
      for (int r = 0; r < 9; r++) cyc(0, 0, 1);
      chk("ab_at9", row_idx, 9);
      cyc(0, 1, 1);
      chk("ab_valid", row_valid, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 1);
         chk("ab_nodone", done, 0);
      end
      cyc(1, 0, 0);
      chk("ab_restart", row_idx, 0);
      finish_sweep();
      cyc(0, 0, 0);

      // Config write during RUN is dropped; write with start in IDLE lands
      cyc(1, 0, 1);
      cyc(0, 0, 1, 1, 1, 16'hFFFF);
      for (int r = 0; r < 4; r++) begin
         chk("f1_frozen", row_out[1], 0);
         cyc(0, 0, 1);
      end
      finish_sweep();
      cyc(0, 0, 0);
      cyc(0, 0, 0, 1, 12, 16'hFFFF);
      cyc(1, 0, 0, 1, 1, 16'hFFFF);
      chk("f1_row0", row_out[1], 1);
      finish_sweep();
      cyc(0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             int'($urandom_range(0, 15)), ROWS'($urandom()));
      end

      // Reset in the middle of a sweep
      if (!ref_run) cyc(1, 0, 1);
      cyc(0, 0, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", row_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_idx", row_idx, 0);
      ref_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1, 0, 1);
      for (int r = 0; r < ROWS; r++) begin
         chk("cleared_masks", row_out, 0);
         cyc(0, 0, 1);
      end
      chk("post_rst_done", done, 1);
      cyc(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
